ram_port_arbiter: RTL

Controller and arbiter for the core's 256×32 single-port block RAM (1-cycle registered read, read-before-write). It shares the RAM between the fetch requester (read-only) and the data requester (load/store) with round-robin arbitration and returns tagged read data one cycle after grant. It also runs an optional post-reset clear sequence that zero-fills the RAM before any request is granted. It sits between the core's fetch/memory stages and the RAM instance.

---
 rtl/ram_port_arbiter_if.sv | 40 ++++
 rtl/ram_port_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the RAM port arbiter and the RAM.
// The arbiter takes the slave side; the core stages and the RAM wrapper take the master side.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic              busy;
    logic [15:0]       conflict_cnt;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_we, ram_addr, ram_din, busy, conflict_cnt
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_we, ram_addr, ram_din, busy, conflict_cnt
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a single-port block RAM between fetch (read-only) and data
// (load/store) requesters, with an optional zero-fill sequence after reset.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input logic           clk,
    input logic           rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic              prio_q;  // 0: fetch wins a tie, 1: data wins a tie
    logic              f_rvalid_q, d_rvalid_q;
    logic [15:0]       conflict_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;

    logic              f_gnt, d_gnt, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              busy;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        we      = 1'b0;
        addr    = addr_q;
        din     = din_q;
        busy    = 1'b0;
        if (rst) begin
            busy = CLEAR_ON_RESET;
        end else begin
            unique case (state_q)
                StClear: begin
                    we    = 1'b1;
                    addr  = clr_q;
                    din   = '0;
                    busy  = 1'b1;
                    clr_d = clr_q + ADDR_W'(1);
                    if (clr_q == '1) state_d = StRun;
                end
                StRun: begin
                    if (bus.f_req && (!bus.d_req || !prio_q)) f_gnt = 1'b1;
                    else if (bus.d_req)                       d_gnt = 1'b1;
                    if (f_gnt) begin
                        addr = bus.f_addr;
                    end else if (d_gnt) begin
                        we   = bus.d_we;
                        addr = bus.d_addr;
                        din  = bus.d_wdata;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StRun;
            clr_q      <= '0;
            prio_q     <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            conflict_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            if (f_gnt)      prio_q <= 1'b1;
            else if (d_gnt) prio_q <= 1'b0;
            f_rvalid_q <= f_gnt;
            d_rvalid_q <= d_gnt & ~bus.d_we;
            if (state_q == StRun && bus.f_req && bus.d_req && conflict_q != 16'hFFFF) begin
                conflict_q <= conflict_q + 16'd1;
            end
            // Idle cycles keep the RAM address/data lines steady.
            addr_q     <= addr;
            din_q      <= din;
        end
    end

    assign bus.f_gnt        = f_gnt;
    assign bus.d_gnt        = d_gnt;
    assign bus.f_rvalid     = f_rvalid_q;
    assign bus.d_rvalid     = d_rvalid_q;
    assign bus.f_rdata      = bus.ram_dout;
    assign bus.d_rdata      = bus.ram_dout;
    assign bus.ram_we       = we;
    assign bus.ram_addr     = addr;
    assign bus.ram_din      = din;
    assign bus.busy         = busy;
    assign bus.conflict_cnt = conflict_q;
endmodule
